// File: rtl/inst_queue.sv
// Circular {inst, pc} FIFO between instruction fetch and decode, cleared on flush.
// Define INST_QUEUE_BYPASS_EN to forward an enqueue straight to the decode side when empty.
module inst_queue #(
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     enq_valid,
    input  logic [31:0]              enq_inst,
    input  logic [31:0]              enq_pc,
    output logic                     enq_ready,
    output logic                     almost_full,
    input  logic                     deq_stall,
    output logic                     deq_valid,
    output logic [31:0]              deq_inst,
    output logic [31:0]              deq_pc,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   inst_mem_q [DEPTH];
    logic [31:0]   pc_mem_q   [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty, full;
    logic          byp, byp_take;
    logic          enq_fire, deq_fire;

    assign empty       = (count_q == '0);
    assign full        = (count_q == CW'(DEPTH));
    assign enq_ready   = !full;
    assign almost_full = (count_q >= CW'(AFULL_THRESH));
    assign count       = count_q;

`ifdef INST_QUEUE_BYPASS_EN
    // Empty queue: the offered entry is presented to decode in the same cycle.
    assign byp = empty & enq_valid & !flush;
`else
    assign byp = 1'b0;
`endif
    assign byp_take = byp & !deq_stall;

    assign deq_fire = !empty & !deq_stall & !flush;
    assign enq_fire = enq_valid & enq_ready & !flush & !byp_take;

    assign deq_valid = !empty | byp;

    always_comb begin
        deq_inst = '0;
        deq_pc   = '0;
        if (!empty) begin
            deq_inst = inst_mem_q[head_q];
            deq_pc   = pc_mem_q[head_q];
        end else if (byp) begin
            deq_inst = enq_inst;
            deq_pc   = enq_pc;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Pointers are exactly log2(DEPTH) wide, so the increment wraps for free.
            if (deq_fire) head_d = head_q + PW'(1);
            if (enq_fire) tail_d = tail_q + PW'(1);
            if (enq_fire && !deq_fire)      count_d = count_q + CW'(1);
            else if (deq_fire && !enq_fire) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: stale slots are never visible because count masks them.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            inst_mem_q[tail_q] <= enq_inst;
            pc_mem_q[tail_q]   <= enq_pc;
        end
    end
endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: vector table, directed corner cases and a random run
// against a queue-based reference model.
module tb_inst_queue;
    localparam int DEPTH = 8;
    localparam int AFT   = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        enq_valid = 1'b0;
    logic [31:0] enq_inst = '0;
    logic [31:0] enq_pc = '0;
    logic        enq_ready;
    logic        almost_full;
    logic        deq_stall = 1'b0;
    logic        deq_valid;
    logic [31:0] deq_inst;
    logic [31:0] deq_pc;
    logic [3:0]  count;

    inst_queue #(.DEPTH(DEPTH), .AFULL_THRESH(AFT)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .enq_valid(enq_valid), .enq_inst(enq_inst), .enq_pc(enq_pc),
        .enq_ready(enq_ready), .almost_full(almost_full),
        .deq_stall(deq_stall), .deq_valid(deq_valid),
        .deq_inst(deq_inst), .deq_pc(deq_pc), .count(count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];   // reference model contents, {inst, pc}, head at index 0
    logic        obs_valid;
    logic [31:0] obs_pc;
    logic [3:0]  obs_count;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0000;
    endfunction

    task automatic check_model();
        logic        ev;
        logic [63:0] ee;
        ev = (exp_q.size() > 0);
        ee = ev ? exp_q[0] : 64'h0;
`ifdef INST_QUEUE_BYPASS_EN
        if (exp_q.size() == 0 && enq_valid && !flush) begin
            ev = 1'b1;
            ee = {enq_inst, enq_pc};
        end
`endif
        chk("model_valid", {63'h0, deq_valid}, {63'h0, ev});
        if (ev) chk("model_entry", {deq_inst, deq_pc}, ee);
        else    chk("model_zero_out", {deq_inst, deq_pc}, 64'h0);
        chk("model_count", {60'h0, count}, 64'(exp_q.size()));
        chk("model_ready", {63'h0, enq_ready}, {63'h0, exp_q.size() < DEPTH});
        chk("model_afull", {63'h0, almost_full}, {63'h0, exp_q.size() >= AFT});
    endtask

    task automatic model_update();
        bit do_deq, do_enq;
        if (flush) begin
            exp_q.delete();
        end else begin
            do_deq = (exp_q.size() > 0) && !deq_stall;
            do_enq = enq_valid && (exp_q.size() < DEPTH);
`ifdef INST_QUEUE_BYPASS_EN
            if (exp_q.size() == 0 && enq_valid && !deq_stall) do_enq = 0;
`endif
            if (do_deq) void'(exp_q.pop_front());
            if (do_enq) exp_q.push_back({enq_inst, enq_pc});
        end
    endtask

    // One clock: apply inputs, compare at negedge, advance model at posedge.
    task automatic step(input logic fl, input logic ev, input logic [31:0] pc,
                        input logic [31:0] inst, input logic st);
        flush = fl; enq_valid = ev; enq_pc = pc; enq_inst = inst; deq_stall = st;
        @(negedge clk);
        obs_valid = deq_valid; obs_pc = deq_pc; obs_count = count;
        check_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; enq_valid = 1'b0; deq_stall = 1'b1;
        enq_pc = '0; enq_inst = '0;
    endtask

    task automatic enq_n(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) step(0, 1, base + 32'(i * 4), inst_of(base + 32'(i * 4)), 1);
    endtask

    typedef struct {
        logic        fl, ev, st;
        logic [31:0] pc;
        logic        x_valid;
        logic [31:0] x_pc;
        logic [3:0]  x_count;
    } vec_t;

    initial begin
        vec_t vt[10];
        int   seq;
        #2;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        chk("reset_count", {60'h0, count}, 64'h0);
        chk("reset_valid", {63'h0, deq_valid}, 64'h0);
        chk("reset_ready", {63'h0, enq_ready}, 64'h1);
        chk("reset_afull", {63'h0, almost_full}, 64'h0);
        chk("reset_out", {deq_inst, deq_pc}, 64'h0);

`ifndef INST_QUEUE_BYPASS_EN
        vt[0] = '{0, 1, 1, 32'h100, 0, 32'h0,   4'd0};
        vt[1] = '{0, 1, 1, 32'h104, 1, 32'h100, 4'd1};
        vt[2] = '{0, 0, 0, 32'h0,   1, 32'h100, 4'd2};
        vt[3] = '{0, 1, 0, 32'h108, 1, 32'h104, 4'd1};
        vt[4] = '{0, 0, 1, 32'h0,   1, 32'h108, 4'd1};
        vt[5] = '{1, 1, 0, 32'h10C, 1, 32'h108, 4'd1};
        vt[6] = '{0, 0, 0, 32'h0,   0, 32'h0,   4'd0};
        vt[7] = '{0, 1, 0, 32'h110, 0, 32'h0,   4'd0};
        vt[8] = '{0, 0, 0, 32'h0,   1, 32'h110, 4'd1};
        vt[9] = '{0, 0, 0, 32'h0,   0, 32'h0,   4'd0};
        for (int i = 0; i < 10; i++) begin
            step(vt[i].fl, vt[i].ev, vt[i].pc, inst_of(vt[i].pc), vt[i].st);
            chk($sformatf("vec%0d_valid", i), {63'h0, obs_valid}, {63'h0, vt[i].x_valid});
            chk($sformatf("vec%0d_pc", i), {32'h0, obs_pc}, {32'h0, vt[i].x_pc});
            chk($sformatf("vec%0d_count", i), {60'h0, obs_count}, {60'h0, vt[i].x_count});
        end
`endif
        step(1, 0, 0, 0, 1);

        // Asynchronous reset while holding three entries.
        enq_n(3, 32'h200);
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {63'h0, deq_valid}, 64'h0);
        chk("rst_mid_count", {60'h0, count}, 64'h0);
        chk("rst_mid_ready", {63'h0, enq_ready}, 64'h1);
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill to full, then drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 32'(i * 4), inst_of(32'(i * 4)), 1);
            idle();
            chk($sformatf("fill%0d_afull", i + 1), {63'h0, almost_full}, {63'h0, (i + 1) >= AFT});
        end
        chk("full_count", {60'h0, count}, 64'd8);
        chk("full_ready", {63'h0, enq_ready}, 64'h0);
        step(0, 1, 32'h20, inst_of(32'h20), 1);
        idle();
        chk("ninth_ignored", {60'h0, count}, 64'd8);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 0, 0, 0, 0);
            chk($sformatf("drain%0d_pc", i), {32'h0, obs_pc}, 64'(i * 4));
        end
        idle();
        chk("drained_valid", {63'h0, deq_valid}, 64'h0);

        // Simultaneous enq and deq at count 4.
        enq_n(4, 32'h300);
        step(0, 1, 32'h340, inst_of(32'h340), 0);
        idle();
        chk("simul_count", {60'h0, count}, 64'd4);
        chk("simul_head", {32'h0, deq_pc}, 64'h304);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        chk("simul_tail", {32'h0, obs_pc}, 64'h340);

        // Flush at count 5 with a concurrent enqueue.
        enq_n(5, 32'h400);
        step(1, 1, 32'h450, inst_of(32'h450), 0);
        idle();
        chk("flush_count", {60'h0, count}, 64'h0);
        chk("flush_valid", {63'h0, deq_valid}, 64'h0);
        step(0, 0, 0, 0, 0);
        chk("flush_absent", {63'h0, obs_valid}, 64'h0);

        // Empty queue, single enqueue with decode ready.
        step(0, 1, 32'h60, inst_of(32'h60), 0);
`ifdef INST_QUEUE_BYPASS_EN
        chk("byp_valid", {63'h0, obs_valid}, 64'h1);
        chk("byp_pc", {32'h0, obs_pc}, 64'h60);
        idle();
        chk("byp_count", {60'h0, count}, 64'h0);
`else
        chk("nobyp_valid", {63'h0, obs_valid}, 64'h0);
        idle();
        chk("nobyp_count", {60'h0, count}, 64'h1);
        chk("nobyp_pc", {32'h0, deq_pc}, 64'h60);
        step(0, 0, 0, 0, 0);
`endif

        // Random traffic across many pointer wraps.
        seq = 0;
        for (int c = 0; c < 400; c++) begin
            logic fl, ev, st;
            fl = ($urandom_range(0, 49) == 0);
            ev = ($urandom_range(0, 9) < 6);
            st = ($urandom_range(0, 9) < 3);
            step(fl, ev, 32'h1000 + 32'(seq * 4), $urandom, st);
            if (ev && enq_ready) seq++;
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
